// File: rtl/fpu_pipe.sv
// fpu_pipe: three-stage IEEE-754 add/sub/mul, round-to-nearest-even, subnormals flushed, valid/ready.
// Define FPU_PIPE_FLAGS_EN to compute and register o_flags; otherwise o_flags is tied to zero.
module fpu_pipe #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int DATA_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter int INST_WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic [INST_WIDTH-1:0] i_inst,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [4:0]            o_flags
);
    localparam int E    = EXP_WIDTH;
    localparam int F    = FRAC_WIDTH;
    localparam int SW   = F + 4;
    localparam int MW   = F + 5;
    localparam int XW   = E + 2;
    localparam int LZW  = $clog2(MW);
    localparam int BIAS = 2 ** (E - 1) - 1;
    localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

    typedef enum logic [2:0] {K_NONE, K_ZERO, K_INF, K_NAN, K_INV} kind_e;

    typedef struct packed {
        kind_e          kind;
        logic           sign;
        logic           is_mul;
        logic           eff_sub;
        logic [XW-1:0]  exp;
        logic [SW-1:0]  sig_l;
        logic [SW-1:0]  sig_s;
    } s1_t;

    typedef struct packed {
        kind_e          kind;
        logic           sign;
        logic [XW-1:0]  exp;
        logic [MW-1:0]  man;
    } s2_t;

    logic [3:1]            vld_pipe;
    logic                  en;
    s1_t                   s1_d, s1_q;
    s2_t                   s2_d, s2_q;
    logic [DATA_WIDTH-1:0] res_d;

    assign en      = ~vld_pipe[3] | i_ready;
    assign o_ready = en;
    assign o_valid = vld_pipe[3];

    // ---- stage 1: unpack, classify, align ----
    logic            sa, sb, sb_eff, za, zb, ia, ib, na, nb, a_big, is_mul, is_sub;
    logic [E-1:0]    ea, eb, ediff;
    logic [F-1:0]    fa, fb;
    logic [E+F-1:0]  ma, mb, kl, ks;
    logic [SW-1:0]   big_sig, sml_sig, sml_mask;

    assign {sa, ea, fa} = i_data_a;
    assign {sb, eb, fb} = i_data_b;
    assign is_mul   = (i_inst == INST_WIDTH'(2));
    assign is_sub   = (i_inst == INST_WIDTH'(1));
    assign sb_eff   = sb ^ is_sub;
    assign za       = (ea == '0);
    assign zb       = (eb == '0);
    assign ia       = (&ea) & (fa == '0);
    assign ib       = (&eb) & (fb == '0);
    assign na       = (&ea) & (|fa);
    assign nb       = (&eb) & (|fb);
    assign ma       = za ? '0 : {ea, fa};
    assign mb       = zb ? '0 : {eb, fb};
    assign a_big    = (ma >= mb);
    assign kl       = a_big ? ma : mb;
    assign ks       = a_big ? mb : ma;
    assign ediff    = kl[E+F-1:F] - ks[E+F-1:F];
    assign big_sig  = (kl[E+F-1:F] == '0) ? '0 : {1'b1, kl[F-1:0], 3'b000};
    assign sml_sig  = (ks[E+F-1:F] == '0) ? '0 : {1'b1, ks[F-1:0], 3'b000};
    assign sml_mask = ~({SW{1'b1}} << ediff);

    always_comb begin
        s1_d        = '0;
        s1_d.is_mul = is_mul;
        if (is_mul) begin
            s1_d.sign  = sa ^ sb;
            s1_d.exp   = XW'(ea) + XW'(eb) - XW'(BIAS);
            s1_d.sig_l = {1'b1, fa, 3'b000};
            s1_d.sig_s = {1'b1, fb, 3'b000};
        end else begin
            s1_d.sign    = a_big ? sa : sb_eff;
            s1_d.eff_sub = sa ^ sb_eff;
            s1_d.exp     = XW'(kl[E+F-1:F]);
            s1_d.sig_l   = big_sig;
            // bits shifted past the field collapse into the sticky LSB
            if (int'(ediff) >= SW)
                s1_d.sig_s = {{(SW-1){1'b0}}, |sml_sig};
            else
                s1_d.sig_s = (sml_sig >> ediff) | {{(SW-1){1'b0}}, |(sml_sig & sml_mask)};
        end
        if (na | nb)
            s1_d.kind = K_NAN;
        else if (is_mul) begin
            if ((ia | ib) & (za | zb)) s1_d.kind = K_INV;
            else if (ia | ib)          s1_d.kind = K_INF;
            else if (za | zb)          s1_d.kind = K_ZERO;
        end else if (ia & ib & (sa != sb_eff))
            s1_d.kind = K_INV;
        else if (ia | ib) begin
            s1_d.kind = K_INF;
            s1_d.sign = ia ? sa : sb_eff;
        end
    end

    // ---- stage 2: significand add/sub or multiply ----
    logic [2*F+1:0] prod;
    logic [MW-1:0]  sum;

    assign prod = {{(F+1){1'b0}}, s1_q.sig_l[SW-1:3]} * {{(F+1){1'b0}}, s1_q.sig_s[SW-1:3]};
    assign sum  = s1_q.eff_sub ? ({1'b0, s1_q.sig_l} - {1'b0, s1_q.sig_s})
                               : ({1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s});

    always_comb begin
        s2_d.kind = s1_q.kind;
        s2_d.exp  = s1_q.exp;
        if (s1_q.is_mul) begin
            s2_d.man  = {prod[2*F+1:F-2], |prod[F-3:0]};
            s2_d.sign = s1_q.sign;
        end else begin
            s2_d.man  = sum;
            s2_d.sign = s1_q.sign & ~(s1_q.eff_sub & (sum == '0));
        end
    end

    // ---- stage 3: normalise, round, pack ----
    logic [LZW-1:0] lz;
    logic [MW-1:0]  sh;
    logic [XW-1:0]  exp_n, e_fin;
    logic [F+1:0]   rnd;
    logic [F-1:0]   frac;
    logic           g, st, rup, zero, ovf, unf;

    always_comb begin
        lz = '0;
        for (int i = 0; i < MW; i++)
            if (s2_q.man[i]) lz = LZW'(MW - 1 - i);
    end

    // unit weight sits at bit MW-2, so a carry into MW-1 means exponent + 1
    assign sh    = s2_q.man << lz;
    assign exp_n = s2_q.exp + XW'(1) - XW'(lz);
    assign g     = sh[3];
    assign st    = |sh[2:0];
    assign rup   = g & (st | sh[4]);
    assign rnd   = {1'b0, sh[MW-1:4]} + (F+2)'(rup);
    assign e_fin = exp_n + XW'(rnd[F+1]);
    assign frac  = rnd[F+1] ? rnd[F:1] : rnd[F-1:0];
    assign zero  = (s2_q.man == '0);
    assign ovf   = ~e_fin[XW-1] & (e_fin[XW-2:0] >= {1'b0, {E{1'b1}}});
    assign unf   = e_fin[XW-1] | (e_fin == '0);

    always_comb begin
        res_d = '0;
        case (s2_q.kind)
            K_NAN, K_INV: res_d = QNAN;
            K_INF:        res_d = {s2_q.sign, {E{1'b1}}, {F{1'b0}}};
            K_ZERO:       res_d = {s2_q.sign, {(E+F){1'b0}}};
            default: begin
                if (zero || unf) res_d = {s2_q.sign, {(E+F){1'b0}}};
                else if (ovf)    res_d = {s2_q.sign, {E{1'b1}}, {F{1'b0}}};
                else             res_d = {s2_q.sign, e_fin[E-1:0], frac};
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            o_data   <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[2:1], i_valid};
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            o_data   <= res_d;
        end
    end

`ifdef FPU_PIPE_FLAGS_EN
    logic [4:0] flags_d;

    always_comb begin
        flags_d = '0;
        if (s2_q.kind == K_INV)
            flags_d[4] = 1'b1;
        else if (s2_q.kind == K_NONE && !zero) begin
            flags_d[2] = ovf;
            flags_d[1] = unf & ~ovf;
            flags_d[0] = ovf | unf | g | st;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_flags <= '0;
        else if (en)
            o_flags <= flags_d;
    end
`else
    assign o_flags = 5'b0;
`endif

endmodule

// File: tb/tb_fpu_pipe.sv
// Directed bench for fpu_pipe: vector table for FP32 results/flags/latency, plus stall and reset sequences.
module tb_fpu_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_data_a = '0;
    logic [31:0] i_data_b = '0;
    logic [1:0]  i_inst = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [4:0]  o_flags;

    always #5 i_clk = ~i_clk;

    fpu_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data_a(i_data_a), .i_data_b(i_data_b),
        .i_inst(i_inst), .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_flags(o_flags)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  inst;
        logic [31:0] res;
        logic [4:0]  flags;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] inst,
                          output logic [31:0] d, output logic [4:0] f, output int lat);
        @(negedge i_clk);
        i_data_a = a; i_data_b = b; i_inst = inst; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(posedge i_clk);
            #1 lat++;
        end
        d = o_data;
        f = o_flags;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[18];
        logic [31:0] vals[10];
        logic [31:0] d, held;
        logic [4:0]  f, exp_fl;
        int          lat, sent, got, cyc, stale;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 2'd0, 32'h40400000, 5'b00000};
        vecs[1]  = '{32'h3FC00000, 32'h40000000, 2'd2, 32'h40400000, 5'b00000};
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 2'd1, 32'h00000000, 5'b00000};
        vecs[3]  = '{32'h7F800000, 32'h00000000, 2'd2, 32'h7FC00000, 5'b10000};
        vecs[4]  = '{32'h7F7FFFFF, 32'h40000000, 2'd2, 32'h7F800000, 5'b00101};
        vecs[5]  = '{32'h4B800000, 32'h3F800000, 2'd0, 32'h4B800000, 5'b00001};
        vecs[6]  = '{32'h4B800001, 32'h3F800000, 2'd0, 32'h4B800002, 5'b00001};
        vecs[7]  = '{32'h80000000, 32'h80000000, 2'd0, 32'h80000000, 5'b00000};
        vecs[8]  = '{32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 5'b00000};
        vecs[9]  = '{32'h7F800000, 32'h7F800000, 2'd1, 32'h7FC00000, 5'b10000};
        vecs[10] = '{32'hFF800000, 32'h3F800000, 2'd0, 32'hFF800000, 5'b00000};
        vecs[11] = '{32'h00000001, 32'h3F800000, 2'd2, 32'h00000000, 5'b00000};
        vecs[12] = '{32'h3F800000, 32'h40000000, 2'd3, 32'h40400000, 5'b00000};
        vecs[13] = '{32'h00800000, 32'h3F000000, 2'd2, 32'h00000000, 5'b00011};
        vecs[14] = '{32'hC0000000, 32'h40400000, 2'd2, 32'hC0C00000, 5'b00000};
        vecs[15] = '{32'h40000000, 32'h3F800000, 2'd1, 32'h3F800000, 5'b00000};
        vecs[16] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 2'd0, 32'h7F800000, 5'b00101};
        vecs[17] = '{32'h3F800000, 32'h33000000, 2'd0, 32'h3F800000, 5'b00001};

        // 1.0 .. 10.0
        vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

        // reset state
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rst_o_valid", {31'b0, o_valid}, 32'd0);
        check("rst_o_data",  o_data, 32'h0);
        check("rst_o_flags", {27'b0, o_flags}, 32'h0);
        check("rst_o_ready", {31'b0, o_ready}, 32'd1);

        // single-op vectors: result, flags, latency
        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].inst, d, f, lat);
`ifdef FPU_PIPE_FLAGS_EN
            exp_fl = vecs[i].flags;
`else
            exp_fl = 5'b0;
`endif
            check($sformatf("vec%0d_data", i), d, vecs[i].res);
            check($sformatf("vec%0d_flags", i), {27'b0, f}, {27'b0, exp_fl});
            check($sformatf("vec%0d_latency", i), lat, 32'd3);
        end

        // burst of 8 with a 4-cycle downstream stall
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        sent = 0; got = 0; cyc = 0; held = '0;
        while (got < 8 && cyc < 100) begin
            i_ready  = !(cyc >= 5 && cyc < 9);
            i_valid  = (sent < 8);
            i_data_a = vals[sent];
            i_data_b = vals[0];
            i_inst   = 2'd0;
            #1;
            if (cyc >= 5 && cyc < 9) begin
                check($sformatf("stall%0d_valid", cyc), {31'b0, o_valid}, 32'd1);
                check($sformatf("stall%0d_ready", cyc), {31'b0, o_ready}, 32'd0);
                if (cyc > 5) check($sformatf("stall%0d_hold", cyc), o_data, held);
                held = o_data;
            end
            if (o_valid && i_ready) begin
                check($sformatf("burst%0d_data", got), o_data, vals[got + 1]);
                got++;
            end
            if (i_valid && o_ready) sent++;
            cyc++;
            @(negedge i_clk);
        end
        check("burst_count", got, 32'd8);
        i_valid = 1'b0;
        i_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_valid) stale++;
        end
        check("burst_no_dup", stale, 32'd0);

        // reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            i_valid = 1'b1; i_data_a = vals[k]; i_data_b = vals[0]; i_inst = 2'd0;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        check("rst_pre_valid", {31'b0, o_valid}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, o_valid}, 32'd0);
        check("rst_mid_data", o_data, 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge i_clk);
            if (o_valid) stale++;
        end
        check("rst_no_stale", stale, 32'd0);
        check("rst_post_ready", {31'b0, o_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
